// File: rtl/square_pipe.sv
// Fully pipelined unsigned squarer: adds one shifted partial product per stage.
// A new operand may enter every clock; a sideband delay line stays aligned with the results.
module square_pipe #(
  parameter  int D_WIDTH    = 16,
  parameter  int USER_WIDTH = 3,
  localparam int P_WIDTH    = 2 * D_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_vaild,
  input  logic [D_WIDTH-1:0]    data_i,
  input  logic [USER_WIDTH-1:0] user_i,
  output logic                  o_vaild,
  output logic [P_WIDTH-1:0]    data_o,
  output logic [USER_WIDTH-1:0] user_o
);

  // Stage k outputs; the operand is not needed after the last stage.
  logic [D_WIDTH-1:0]    a_s    [0:D_WIDTH-1];
  logic [P_WIDTH-1:0]    acc_s  [0:D_WIDTH];
  logic                  v_s    [0:D_WIDTH];
  logic [USER_WIDTH-1:0] user_s [0:D_WIDTH];

  logic [D_WIDTH-1:0]    a0_q, a0_d;
  logic [P_WIDTH-1:0]    acc0_q, acc0_d;
  logic                  v0_q, v0_d;
  logic [USER_WIDTH-1:0] user0_q, user0_d;

  always_comb begin
    acc0_d  = {P_WIDTH{1'b0}};
    user0_d = user_i;
    if (i_vaild) begin
      a0_d = data_i;
      v0_d = 1'b1;
    end else begin
      a0_d = {D_WIDTH{1'b0}};
      v0_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q    <= {D_WIDTH{1'b0}};
      acc0_q  <= {P_WIDTH{1'b0}};
      v0_q    <= 1'b0;
      user0_q <= {USER_WIDTH{1'b0}};
    end else begin
      a0_q    <= a0_d;
      acc0_q  <= acc0_d;
      v0_q    <= v0_d;
      user0_q <= user0_d;
    end
  end

  assign a_s[0]    = a0_q;
  assign acc_s[0]  = acc0_q;
  assign v_s[0]    = v0_q;
  assign user_s[0] = user0_q;

  for (genvar k = 1; k <= D_WIDTH; k++) begin : g_stage
    logic [P_WIDTH-1:0]    acc_q, acc_d;
    logic                  v_q, v_d;
    logic [USER_WIDTH-1:0] user_q, user_d;

    // Invalid slots are flushed to zero so bubbles never carry stale data.
    always_comb begin
      user_d = user_s[k-1];
      if (v_s[k-1]) begin
        v_d = 1'b1;
        if (a_s[k-1][k-1]) begin
          acc_d = acc_s[k-1] + ({{D_WIDTH{1'b0}}, a_s[k-1]} << (k - 1));
        end else begin
          acc_d = acc_s[k-1];
        end
      end else begin
        v_d   = 1'b0;
        acc_d = {P_WIDTH{1'b0}};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q  <= {P_WIDTH{1'b0}};
        v_q    <= 1'b0;
        user_q <= {USER_WIDTH{1'b0}};
      end else begin
        acc_q  <= acc_d;
        v_q    <= v_d;
        user_q <= user_d;
      end
    end

    assign acc_s[k]  = acc_q;
    assign v_s[k]    = v_q;
    assign user_s[k] = user_q;

    if (k < D_WIDTH) begin : g_fwd
      logic [D_WIDTH-1:0] a_q, a_d;

      always_comb begin
        if (v_s[k-1]) begin
          a_d = a_s[k-1];
        end else begin
          a_d = {D_WIDTH{1'b0}};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= {D_WIDTH{1'b0}};
        end else begin
          a_q <= a_d;
        end
      end

      assign a_s[k] = a_q;
    end
  end

  assign o_vaild = v_s[D_WIDTH];
  assign data_o  = acc_s[D_WIDTH];
  assign user_o  = user_s[D_WIDTH];

endmodule

// File: tb/tb_square_pipe.sv
// Self-checking bench for square_pipe: a per-cycle scoreboard plus scenario tasks
// that check latency, extremes, streaming, sideband alignment and reset behaviour.
module tb_square_pipe;
  localparam int DW  = 16;
  localparam int UW  = 3;
  localparam int PW  = 32;
  localparam int LAT = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          i_vaild = 1'b0;
  logic [DW-1:0] data_i  = 16'h0000;
  logic [UW-1:0] user_i  = 3'h0;
  logic          o_vaild;
  logic [PW-1:0] data_o;
  logic [UW-1:0] user_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          v;
    logic [PW-1:0] d;
    logic [UW-1:0] u;
  } exp_t;
  exp_t sb[$];

  square_pipe #(.D_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n), .i_vaild(i_vaild), .data_i(data_i), .user_i(user_i),
    .o_vaild(o_vaild), .data_o(data_o), .user_o(user_o)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] sq(input logic [DW-1:0] x);
    logic [PW-1:0] e;
    e = {16'h0000, x};
    return e * e;
  endfunction

  // Reference model: record what each accepted edge should produce LAT edges later.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      sb.push_back('{v: i_vaild, d: (i_vaild ? sq(data_i) : 32'h0), u: user_i});
    end
  end

  // Cycle-for-cycle comparison of the DUT outputs against the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    #1;
    checks++;
    if (rst_n !== 1'b1) begin
      sb.delete();
      if (o_vaild !== 1'b0 || data_o !== 32'h0 || user_o !== 3'h0) begin
        errors++;
        $display("FAIL sb_reset got v=%b d=%h u=%h want zeros", o_vaild, data_o, user_o);
      end
    end else if (sb.size() > LAT) begin
      e = sb.pop_front();
      if (o_vaild !== e.v || data_o !== e.d || user_o !== e.u) begin
        errors++;
        $display("FAIL sb_cycle t=%0t got v=%b d=%h u=%h want v=%b d=%h u=%h",
                 $time, o_vaild, data_o, user_o, e.v, e.d, e.u);
      end
    end else if (o_vaild !== 1'b0 || data_o !== 32'h0 || user_o !== 3'h0) begin
      errors++;
      $display("FAIL sb_fill got v=%b d=%h u=%h want zeros", o_vaild, data_o, user_o);
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_vaild = 1'($urandom_range(0, 1));
      data_i  = 16'($urandom);
      user_i  = 3'($urandom);
      @(negedge clk);
      #2;
      checks++;
      if (o_vaild !== 1'b0 || data_o !== 32'h0 || user_o !== 3'h0) begin
        errors++;
        $display("FAIL reset_hold got v=%b d=%h u=%h want zeros", o_vaild, data_o, user_o);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; i_vaild = 1'b0; data_i = 16'h0000; user_i = 3'h0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      checks++;
      if (o_vaild !== 1'b0 || data_o !== 32'h0 || user_o !== 3'h0) begin
        errors++;
        $display("FAIL reset_idle got v=%b d=%h u=%h want zeros", o_vaild, data_o, user_o);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int hits = 0;
    int hit_at = -1;
    logic [PW-1:0] got = 32'h0;
    data_i = 16'h00FF; i_vaild = 1'b1;
    @(negedge clk);
    i_vaild = 1'b0; data_i = 16'h0000;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (o_vaild === 1'b1) begin
        hits++; hit_at = k; got = data_o;
      end
    end
    checks++;
    if (hits != 1) begin errors++; $display("FAIL single_count got %0d want 1", hits); end
    checks++;
    if (hit_at != LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", hit_at, LAT); end
    checks++;
    if (got !== 32'h0000FE01) begin errors++; $display("FAIL single_data got %h want 0000fe01", got); end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    logic [DW-1:0] ops [3];
    logic [PW-1:0] want [3];
    logic [PW-1:0] got [$];
    ops  = '{16'hFFFF, 16'h0000, 16'h8000};
    want = '{32'hFFFE0001, 32'h00000000, 32'h40000000};
    for (int i = 0; i < 3; i++) begin
      data_i = ops[i]; i_vaild = 1'b1;
      @(negedge clk);
    end
    i_vaild = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (o_vaild === 1'b1) got.push_back(data_o);
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL extremes_count got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++; $display("FAIL extremes_data[%0d] got %h want %h", i, got[i], want[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    fork
      begin
        for (int i = 1; i <= 200; i++) begin
          data_i = 16'(i); i_vaild = 1'b1;
          @(negedge clk);
        end
        i_vaild = 1'b0;
      end
      begin
        int waited = 0;
        while (o_vaild !== 1'b1 && waited < 60) begin
          @(posedge clk); #1; waited++;
        end
        checks++;
        if (waited >= 60) begin
          errors++; $display("FAIL stream_timeout got no o_vaild want one within 60 cycles");
        end else begin
          for (int i = 1; i <= 200; i++) begin
            checks++;
            if (o_vaild !== 1'b1 || data_o !== 32'(i * i)) begin
              errors++;
              $display("FAIL stream[%0d] got v=%b d=%0d want v=1 d=%0d", i, o_vaild, data_o, i * i);
            end
            @(posedge clk); #1;
          end
        end
      end
    join
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    int n_in = 0;
    int n_out = 0;
    fork
      begin
        for (int c = 0; c < 300; c++) begin
          i_vaild = ($urandom_range(0, 2) != 0);
          data_i  = 16'($urandom);
          user_i  = 3'($urandom);
          n_in += int'(i_vaild);
          @(negedge clk);
        end
        i_vaild = 1'b0;
      end
      begin
        for (int c = 0; c < 340; c++) begin
          @(posedge clk); #1;
          if (o_vaild === 1'b1) n_out++;
          else if (data_o !== 32'h0) begin
            checks++; errors++;
            $display("FAIL random_bubble got d=%h want 0", data_o);
          end
        end
      end
    join
    checks++;
    if (n_out != n_in) begin errors++; $display("FAIL random_count got %0d want %0d", n_out, n_in); end
    @(negedge clk);
  endtask

  task automatic test_sideband();
    fork
      begin
        for (int k = 0; k < 64; k++) begin
          user_i = 3'(k); i_vaild = 1'(k % 2); data_i = 16'(k * 7);
          @(negedge clk);
        end
        i_vaild = 1'b0;
      end
      begin
        for (int j = 0; j < 80; j++) begin
          @(posedge clk); #1;
          if (j >= LAT && j - LAT < 64) begin
            checks++;
            if (user_o !== 3'(j - LAT) || o_vaild !== 1'((j - LAT) % 2)) begin
              errors++;
              $display("FAIL sideband[%0d] got u=%0d v=%b want u=%0d v=%0d",
                       j - LAT, user_o, o_vaild, (j - LAT) % 8, (j - LAT) % 2);
            end
          end
        end
      end
    join
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] got [$];
    for (int i = 0; i < 10; i++) begin
      data_i = 16'(100 + i); i_vaild = 1'b1;
      if (i == 5) rst_n = 1'b0;
      if (i == 6) rst_n = 1'b1;
      @(negedge clk);
    end
    i_vaild = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (o_vaild === 1'b1) got.push_back(data_o);
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL midreset_count got %0d want 4", got.size());
    end else begin
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (got[n] !== 32'((106 + n) * (106 + n))) begin
          errors++; $display("FAIL midreset_data[%0d] got %0d want %0d", n, got[n], (106 + n) * (106 + n));
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_stream();
    test_random();
    test_sideband();
    test_reset_mid();
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
